// File: rtl/store_pack.sv
// Store packing queue: turns (addr, wdata, size) store requests into word-aligned
// byte-lane data with byte enables, flags misaligned/illegal stores, and buffers them FIFO.
module store_pack #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [1:0]  in_size,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_addr,
   output logic [31:0] out_data,
   output logic [3:0]  out_be,
   output logic        out_err,
   output logic [7:0]  err_count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] data;
      logic [3:0]  be;
      logic        err;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          new_e;
   entry_t          head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            accept;
   logic            pop;
   logic            misaligned;

   assign in_ready  = (count < FULL);
   assign out_valid = (count != '0);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Illegal size keeps the raw register value on the lanes; only be/err mark it.
   always_comb begin
      new_e       = '0;
      misaligned  = 1'b0;
      new_e.waddr = in_addr[31:2];
      unique case (in_size)
         2'b00: begin
            new_e.data = {4{in_wdata[7:0]}};
            new_e.be   = 4'b0001 << in_addr[1:0];
         end
         2'b01: begin
            new_e.data = {2{in_wdata[15:0]}};
            new_e.be   = in_addr[1] ? 4'b1100 : 4'b0011;
            misaligned = in_addr[0];
         end
         2'b10: begin
            new_e.data = in_wdata;
            new_e.be   = 4'b1111;
            misaligned = (in_addr[1:0] != 2'b00);
         end
         default: begin
            new_e.data = in_wdata;
            misaligned = 1'b1;
         end
      endcase
      if (misaligned) begin
         new_e.be = '0;
      end
      new_e.err = misaligned;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= new_e;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         err_count <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (accept && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !accept) begin
            count <= count - 1'b1;
         end
         if (accept && new_e.err && (err_count != 8'hFF)) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

   // Outputs are masked to zero whenever the queue is empty, including during reset.
   assign head     = mem[rd_ptr];
   assign out_addr = out_valid ? {head.waddr, 2'b00} : '0;
   assign out_data = out_valid ? head.data : '0;
   assign out_be   = out_valid ? head.be : '0;
   assign out_err  = out_valid ? head.err : 1'b0;

endmodule

// File: tb/tb_store_pack.sv
// Bench for store_pack: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_store_pack;
   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [1:0]  in_size;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [3:0]  out_be;
   logic        out_err;
   logic [7:0]  err_count;

   store_pack #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
      .out_err(out_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic        err;
   } exp_t;

   exp_t        q[$];
   int unsigned ecnt;
   int          errors = 0;
   int          checks = 0;
   bit          m_acc;
   bit          m_pop;
   exp_t        m_new;

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      exp_t        e;
      int unsigned off;
      bit          bad;
      off    = int'(a % 4);
      e.addr = a - off;
      bad    = 1'b0;
      case (s)
         2'd0: begin e.data = {4{d[7:0]}};  e.be = 4'(1 << off); end
         2'd1: begin e.data = {2{d[15:0]}}; e.be = (off >= 2) ? 4'hC : 4'h3; bad = (off % 2) != 0; end
         2'd2: begin e.data = d;            e.be = 4'hF; bad = (off != 0); end
         default: begin e.data = d;         e.be = 4'h0; bad = 1'b1; end
      endcase
      if (bad) e.be = 4'h0;
      e.err = bad;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: state changes on accepted / popped requests only.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q.delete();
         ecnt = 0;
      end else begin
         m_acc = in_valid && (q.size() < DEPTH);
         m_pop = out_ready && (q.size() > 0);
         m_new = model(in_addr, in_wdata, in_size);
         if (m_pop) void'(q.pop_front());
         if (m_acc) begin
            q.push_back(m_new);
            if (m_new.err && ecnt < 255) ecnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (q.size() == 0) begin
            check("valid", {31'd0, out_valid}, 32'd0);
            check("addr",  out_addr, 32'd0);
            check("data",  out_data, 32'd0);
            check("be",    {28'd0, out_be}, 32'd0);
            check("err",   {31'd0, out_err}, 32'd0);
         end else begin
            check("valid", {31'd0, out_valid}, 32'd1);
            check("addr",  out_addr, q[0].addr);
            check("data",  out_data, q[0].data);
            check("be",    {28'd0, out_be}, {28'd0, q[0].be});
            check("err",   {31'd0, out_err}, {31'd0, q[0].err});
         end
         check("in_ready",  {31'd0, in_ready}, {31'd0, (q.size() < DEPTH)});
         check("err_count", {24'd0, err_count}, ecnt);
      end
   end

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      in_valid = v; in_addr = a; in_wdata = d; in_size = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; out_ready = 1'b0;
      drive(0, 32'd0, 32'd0, 2'd0);
      #3;
      check("rst_valid",  {31'd0, out_valid}, 32'd0);
      check("rst_ready",  {31'd0, in_ready}, 32'd1);
      check("rst_errcnt", {24'd0, err_count}, 32'd0);
      #9 rstn = 1'b1;
      tick();

      // byte store into the top lane
      out_ready = 1'b1;
      drive(1, 32'h1003, 32'h0000_00AB, 2'd0);
      tick();
      drive(0, 32'd0, 32'd0, 2'd0);
      @(negedge clk);
      check("sb_addr", out_addr, 32'h1000);
      check("sb_data", out_data, 32'hABAB_ABAB);
      check("sb_be",   {28'd0, out_be}, 32'h8);
      check("sb_err",  {31'd0, out_err}, 32'd0);
      tick();

      // half store then misaligned word
      out_ready = 1'b0;
      drive(1, 32'h2002, 32'h1234_CDEF, 2'd1);
      tick();
      drive(1, 32'h2001, 32'h5566_7788, 2'd2);
      tick();
      drive(0, 32'd0, 32'd0, 2'd0);
      @(negedge clk);
      check("sh_data", out_data, 32'hCDEF_CDEF);
      check("sh_be",   {28'd0, out_be}, 32'hC);
      check("sw_errcnt", {24'd0, err_count}, 32'd1);
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("sw_err", {31'd0, out_err}, 32'd1);
      check("sw_be",  {28'd0, out_be}, 32'd0);
      tick();

      // fill while stalled
      out_ready = 1'b0;
      drive(1, 32'h3000, 32'h1111_1111, 2'd2);
      tick();
      drive(1, 32'h3004, 32'h2222_2222, 2'd2);
      tick();
      drive(0, 32'd0, 32'd0, 2'd0);
      @(negedge clk);
      check("full_ready", {31'd0, in_ready}, 32'd0);
      check("full_head",  out_data, 32'h1111_1111);
      tick(); tick();
      @(negedge clk);
      check("stall_head", out_data, 32'h1111_1111);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("no_comb_ready", {31'd0, in_ready}, 32'd0);
      tick();
      @(negedge clk);
      check("ready_after_pop", {31'd0, in_ready}, 32'd1);
      check("second_out", out_data, 32'h2222_2222);
      tick();

      // occupancy 1 with simultaneous accept and pop
      out_ready = 1'b0;
      drive(1, 32'h4000, 32'hA000_0000, 2'd2);
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'h4000 + 32'(4 * (i + 1)), 32'hA000_0000 + 32'(i + 1), 2'd2);
         tick();
         @(negedge clk);
         check("occ1_data", out_data, 32'hA000_0000 + 32'(i + 1));
      end
      drive(0, 32'd0, 32'd0, 2'd0);
      tick();

      // randomized traffic
      repeat (3000) begin
         drive(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drive(0, 32'd0, 32'd0, 2'd0);
      out_ready = 1'b1;
      tick(); tick(); tick();

      // err_count saturation
      repeat (300) begin
         drive(1, $urandom, $urandom, 2'd3);
         tick();
      end
      drive(0, 32'd0, 32'd0, 2'd0);
      tick();
      @(negedge clk);
      check("errcnt_sat", {24'd0, err_count}, 32'd255);
      tick();

      // asynchronous reset with entries queued
      out_ready = 1'b0;
      drive(1, 32'h5000, 32'hDEAD_BEEF, 2'd2);
      tick();
      drive(1, 32'h5004, 32'hFEED_F00D, 2'd2);
      tick();
      drive(0, 32'd0, 32'd0, 2'd0);
      #2 rstn = 1'b0;
      #1;
      check("arst_valid",  {31'd0, out_valid}, 32'd0);
      check("arst_ready",  {31'd0, in_ready}, 32'd1);
      check("arst_errcnt", {24'd0, err_count}, 32'd0);
      check("arst_data",   out_data, 32'd0);
      #10 rstn = 1'b1;
      tick();
      drive(1, 32'h6002, 32'h0000_00C3, 2'd0);
      tick();
      drive(0, 32'd0, 32'd0, 2'd0);
      @(negedge clk);
      check("post_rst_addr", out_addr, 32'h6000);
      check("post_rst_be",   {28'd0, out_be}, 32'h4);
      check("post_rst_data", out_data, 32'hC3C3_C3C3);
      tick();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
